// File: rtl/fp_add_seq_pkg.sv
// fp_add_seq_pkg: widths, saturation limits, FSM encoding and operand expansion shared by the adder
package fp_add_seq_pkg;
  localparam int EXP_W = 3;
  localparam int FRAC_W = 4;
  localparam int INT_W = 13;
  localparam logic [EXP_W-1:0] SAT_E = 3'd7;
  localparam logic [FRAC_W-1:0] SAT_F = 4'd15;
  typedef enum logic [2:0] {IDLE, LOAD, SUM, NORM, RND} state_t;
  function automatic logic signed [INT_W-1:0] expand(input logic s, input logic [EXP_W-1:0] e,
                                                     input logic [FRAC_W-1:0] f);
    logic signed [INT_W-1:0] m;
    m = INT_W'(f) << e;
    return s ? -m : m;
  endfunction
endpackage

// File: rtl/fp_add_seq_if.sv
// fp_add_seq_if: operand/request and result/status bundle of the sequential float adder
interface fp_add_seq_if;
  import fp_add_seq_pkg::*;
  logic start, sub, SA, SB, S, busy, done, ovf;
  logic [EXP_W-1:0] EA, EB, E;
  logic [FRAC_W-1:0] FA, FB, F;
  modport master (output start, sub, SA, EA, FA, SB, EB, FB, input S, E, F, busy, done, ovf);
  modport slave (input start, sub, SA, EA, FA, SB, EB, FB, output S, E, F, busy, done, ovf);
endinterface

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalizes a 12-bit magnitude to 4-bit significand, rounds half-up, saturates
module fp_norm_round
  import fp_add_seq_pkg::*;
(
  input  logic [INT_W-2:0]  m,
  output logic [EXP_W-1:0]  e,
  output logic [FRAC_W-1:0] f,
  output logic              ovf
);
  logic [3:0] p;
  logic [4:0] sh, sum, ex;
  logic big;
  always_comb begin
    p = '0;
    for (int i = 0; i < INT_W - 1; i++) p = m[i] ? 4'(i) : p;
    big = p >= 4'd4;
    // sh[4:1] is the kept significand, sh[0] the round bit
    sh = 5'(m >> (p - 4'd4));
    sum = {1'b0, sh[4:1]} + {4'b0, sh[0]};
    ex = {1'b0, p} - 5'd3 + {4'b0, sum[4]};
    ovf = big && ex > 5'd7;
    e = !big ? '0 : ovf ? SAT_E : ex[2:0];
    f = !big ? m[3:0] : ovf ? SAT_F : sum[4] ? 4'd8 : sum[3:0];
  end
endmodule

// File: rtl/fp_add_seq.sv
// fp_add_seq: five-state sequential adder/subtractor for the (S,E,F) integer-float format
module fp_add_seq
  import fp_add_seq_pkg::*;
(
  input logic clk,
  input logic rst_n,
  fp_add_seq_if.slave io
);
  state_t state, nxt;
  logic sub_q, sa_q, sb_q;
  logic [EXP_W-1:0] ea_q, eb_q, e_n;
  logic [FRAC_W-1:0] fa_q, fb_q, f_n;
  logic signed [INT_W-1:0] a_i, b_i, r;
  logic [INT_W-2:0] m;
  logic ovf_n;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
  always_comb begin
    nxt = state == IDLE ? (io.start ? LOAD : IDLE) :
          state == LOAD ? SUM : state == SUM ? NORM : state == NORM ? RND : IDLE;
  end
  always_comb begin
    io.busy = state != IDLE;
    io.done = state == RND;
  end
  assign m = (INT_W-1)'(r[INT_W-1] ? -r : r);
  fp_norm_round u_nr (.m(m), .e(e_n), .f(f_n), .ovf(ovf_n));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {sub_q, sa_q, sb_q, ea_q, eb_q, fa_q, fb_q} <= '0;
      {a_i, b_i, r} <= '0;
      {io.S, io.E, io.F, io.ovf} <= '0;
    end else begin
      if (state == IDLE && io.start) begin
        {sub_q, sa_q, ea_q, fa_q, sb_q, eb_q, fb_q} <= {io.sub, io.SA, io.EA, io.FA, io.SB, io.EB, io.FB};
      end
      if (state == LOAD) begin
        a_i <= expand(sa_q, ea_q, fa_q);
        b_i <= expand(sb_q, eb_q, fb_q);
      end
      if (state == SUM) r <= sub_q ? a_i - b_i : a_i + b_i;
      // results land on entry to RND so they are valid alongside done
      if (state == NORM) {io.S, io.E, io.F, io.ovf} <= {r[INT_W-1], e_n, f_n, ovf_n};
    end
  end
endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: directed and random scoreboard bench for fp_add_seq
module tb_fp_add_seq;
  import fp_add_seq_pkg::*;
  typedef struct packed {logic s; logic [2:0] e; logic [3:0] f; logic ovf;} res_t;
  logic clk = 0, rst_n = 0;
  int tests = 0, fails = 0;
  res_t sb_q[$];
  fp_add_seq_if io();
  fp_add_seq dut (.clk(clk), .rst_n(rst_n), .io(io.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input int sa, ea, fa, sb, eb, fb, sub);
    res_t o;
    int a, b, r, mg, e, f;
    a = (fa << ea) * (sa != 0 ? -1 : 1);
    b = (fb << eb) * (sb != 0 ? -1 : 1);
    r = sub != 0 ? a - b : a + b;
    mg = r < 0 ? -r : r;
    e = 0;
    f = mg;
    o.ovf = 0;
    if (mg >= 16) begin
      while ((mg >> e) >= 16) e++;
      f = (mg + (1 << (e - 1))) >> e;
      if (f == 16) begin f = 8; e++; end
    end
    if (e > 7) begin e = 7; f = 15; o.ovf = 1; end
    o.s = r < 0;
    o.e = 3'(e);
    o.f = 4'(f);
    return o;
  endfunction

  task automatic drive(input logic sa, input logic [2:0] ea, input logic [3:0] fa,
                       input logic sb, input logic [2:0] eb, input logic [3:0] fb, input logic sub);
    {io.SA, io.EA, io.FA, io.SB, io.EB, io.FB, io.sub} = {sa, ea, fa, sb, eb, fb, sub};
  endtask

  task automatic run(input logic sa, input logic [2:0] ea, input logic [3:0] fa,
                     input logic sb, input logic [2:0] eb, input logic [3:0] fb,
                     input logic sub, input bit restart);
    res_t exp_r = '0;
    @(negedge clk);
    drive(sa, ea, fa, sb, eb, fb, sub);
    io.start = 1;
    sb_q.push_back(model(sa, ea, fa, sb, eb, fb, sub));
    @(posedge clk); #1;
    io.start = 0;
    drive(1'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), 3'($urandom), 4'($urandom), 1'($urandom));
    for (int c = 1; c <= 4; c++) begin
      if (restart && c == 2) io.start = 1;
      if (c == 3) io.start = 0;
      chk($sformatf("busy_c%0d", c), 32'(io.busy), 32'd1);
      chk($sformatf("done_c%0d", c), 32'(io.done), 32'(c == 4));
      if (io.done === 1'b1) begin
        chk("sb_pending", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) exp_r = sb_q.pop_front();
        chk("S", 32'(io.S), 32'(exp_r.s));
        chk("E", 32'(io.E), 32'(exp_r.e));
        chk("F", 32'(io.F), 32'(exp_r.f));
        chk("ovf", 32'(io.ovf), 32'(exp_r.ovf));
      end
      @(posedge clk); #1;
    end
    chk("busy_idle", 32'(io.busy), 32'd0);
    chk("done_idle", 32'(io.done), 32'd0);
    chk("hold", 32'({io.S, io.E, io.F, io.ovf}), 32'(exp_r));
    if (restart) begin
      @(posedge clk); #1;
      chk("no_second_done", 32'(io.done), 32'd0);
      chk("no_second_busy", 32'(io.busy), 32'd0);
    end
  endtask

  initial begin
    io.start = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'({io.S, io.E, io.F, io.ovf}), 32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_done", 32'(io.done), 32'd0);
    @(negedge clk);
    rst_n = 1;
    run(0, 0, 5, 0, 0, 3, 0, 0);
    run(0, 7, 15, 0, 7, 15, 0, 0);
    run(0, 1, 15, 0, 0, 1, 0, 0);
    run(0, 2, 9, 0, 2, 9, 1, 0);
    run(1, 3, 12, 0, 0, 4, 0, 0);
    run(1, 3, 12, 0, 0, 4, 0, 1);
    // abort an operation with reset in cycle 2, then restart at cycle 4
    @(negedge clk);
    drive(0, 3, 9, 0, 0, 1, 0);
    io.start = 1;
    @(posedge clk); #1;
    io.start = 0;
    rst_n = 0;
    @(posedge clk); #1;
    chk("abort_out", 32'({io.S, io.E, io.F, io.ovf}), 32'd0);
    chk("abort_busy", 32'(io.busy), 32'd0);
    chk("abort_done", 32'(io.done), 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("abort_nodone", 32'(io.done), 32'd0);
    chk("abort_idle", 32'(io.busy), 32'd0);
    run(0, 4, 11, 1, 2, 7, 1, 0);
    for (int i = 0; i < 8; i++)
      run(1'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), 0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
